ps2_rx: RTL

PS2_RX -- requirements
Module: ps2_rx

---
 rtl/ag_ps2_pkg.sv | 13 +
 rtl/ps2_rx_if.sv | 13 +
 rtl/ps2_filter.sv | 34 +++
 rtl/ps2_rx.sv | 109 ++++++++++
 4 files changed

// File: rtl/ag_ps2_pkg.sv
// Shared PS/2 receiver types: FSM state encoding, break-code constant and parity helper.
package ag_ps2_pkg;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_e;

    localparam logic [7:0] BRK_CODE = 8'hF0;

    // Odd parity holds when the data byte plus parity bit carry an odd number of ones.
    function automatic logic odd_par_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_rx_if.sv
// PS/2 line inputs and received-byte outputs of the receiver, bundled for port connection.
interface ps2_rx_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] data;
    logic       valid;
    logic       err;
    logic       busy;
    logic       brk;

    modport master (input ps2_clk, ps2_data, output data, valid, err, busy, brk);
    modport slave  (output ps2_clk, ps2_data, input data, valid, err, busy, brk);
endinterface

// File: rtl/ps2_filter.sv
// Two-flop synchronizer plus glitch filter: the output follows the input only after
// FILT_LEN consecutive synchronized samples disagree with it.
module ps2_filter #(
    parameter int FILT_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);
    localparam int CW = $clog2(FILT_LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(FILT_LEN - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b11;
            cnt  <= '0;
            dout <= 1'b1;
        end else begin
            sync <= {sync[0], din};
            if (sync[1] == dout) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                dout <= sync[1];
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: filtered line sampling, frame FSM with parity/stop/timeout checks.
// Define PS2_RX_BREAK_EN to fold the F0 release prefix into a brk flag on the following byte.
module ps2_rx
    import ag_ps2_pkg::*;
#(
    parameter int FILT_LEN    = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    ps2_rx_if.master    bus
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    logic          fclk, fdat, fclk_q;
    logic          fall, tmo_hit, samp, stop_ok, acc, bad, hold, deliver;
    ps2_state_e    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [TW-1:0] tmo_cnt;
    logic          brk_r;

    ps2_filter #(.FILT_LEN(FILT_LEN)) u_filt_clk (.clk(clk), .rst_n(rst_n), .din(bus.ps2_clk),  .dout(fclk));
    ps2_filter #(.FILT_LEN(FILT_LEN)) u_filt_dat (.clk(clk), .rst_n(rst_n), .din(bus.ps2_data), .dout(fdat));

    assign fall    = fclk_q & ~fclk;
    // Timeout wins over a coincident sample edge.
    assign tmo_hit = (state != IDLE) && (tmo_cnt == TMO_LAST);
    assign samp    = fall & ~tmo_hit;
    assign stop_ok = fdat & odd_par_ok(shreg, par_bit);
    assign acc     = (state == STOP) & samp & stop_ok;
    assign bad     = (state == STOP) & samp & ~stop_ok;

`ifdef PS2_RX_BREAK_EN
    logic pend;
    assign hold = acc & (shreg == BRK_CODE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend  <= 1'b0;
            brk_r <= 1'b0;
        end else begin
            brk_r <= deliver & pend;
            if (bad || tmo_hit || deliver) pend <= 1'b0;
            else if (hold)                 pend <= 1'b1;
        end
    end
`else
    assign hold  = 1'b0;
    assign brk_r = 1'b0;
`endif

    assign deliver = acc & ~hold;
    assign bus.brk = brk_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            fclk_q    <= 1'b1;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            tmo_cnt   <= '0;
            bus.data  <= 8'h00;
            bus.valid <= 1'b0;
            bus.err   <= 1'b0;
            bus.busy  <= 1'b0;
        end else begin
            fclk_q    <= fclk;
            bus.valid <= deliver;
            bus.err   <= bad | tmo_hit;
            if (deliver) bus.data <= shreg;

            if (state == IDLE || fall) tmo_cnt <= '0;
            else                       tmo_cnt <= tmo_cnt + 1'b1;

            if (tmo_hit) begin
                state    <= IDLE;
                bus.busy <= 1'b0;
                bit_cnt  <= '0;
                shreg    <= '0;
                tmo_cnt  <= '0;
            end else if (samp) begin
                case (state)
                    IDLE: if (!fdat) begin
                        state    <= DATA;
                        bus.busy <= 1'b1;
                        bit_cnt  <= '0;
                    end
                    DATA: begin
                        shreg   <= {fdat, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        par_bit <= fdat;
                        state   <= STOP;
                    end
                    default: begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
